// File: rtl/dram_pkg.sv
// Command/error encodings and FSM state type shared by the DRAM command responder.
// Latency: n/a (types only); backpressure: n/a.
package dram_pkg;

    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_RW  = 2'b01,
        CMD_REF = 2'b10,
        CMD_PRE = 2'b11
    } cmd_e;

    localparam logic [1:0] ERR_NONE         = 2'b00;
    localparam logic [1:0] ERR_ACT_ON_OPEN  = 2'b01;
    localparam logic [1:0] ERR_ROW_MISS     = 2'b10;
    localparam logic [1:0] ERR_REF_NOT_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

endpackage

// File: rtl/dram_bank_table.sv
// Per-bank open bit and open-row register with combinational lookup and open/close write ports.
// Latency: lookup 0 cycles, writes visible next cycle; backpressure: none.
module dram_bank_table
    import dram_pkg::*;
#(
    parameter int NB = 8,
    parameter int BW = 3,
    parameter int RW = 7
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [BW-1:0] lk_bank_i,
    output logic          lk_open_o,
    output logic [RW-1:0] lk_row_o,
    output logic          any_open_o,
    input  logic          open_en_i,
    input  logic          close_en_i,
    input  logic [BW-1:0] wr_bank_i,
    input  logic [RW-1:0] wr_row_i,
    output logic [NB-1:0] banks_open_o
);

    logic [NB-1:0] open_q, open_d;
    logic [RW-1:0] row_q [NB];

    always_comb begin
        open_d = open_q;
        if (open_en_i)  open_d[wr_bank_i] = 1'b1;
        if (close_en_i) open_d[wr_bank_i] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            open_q <= '0;
            for (int b = 0; b < NB; b++) row_q[b] <= '0;
        end else begin
            open_q <= open_d;
            if (open_en_i) row_q[wr_bank_i] <= wr_row_i;
        end
    end

    assign lk_open_o    = open_q[lk_bank_i];
    assign lk_row_o     = row_q[lk_bank_i];
    assign any_open_o   = |open_q;
    assign banks_open_o = open_q;

endmodule

// File: rtl/dram_cmd_responder.sv
// DRAM target model: accepts one command at a time, checks legality, acks after its timing latency, tracks refresh due.
// Latency: req in cycle N -> cmd_ack in N+1+T; backpressure: inputs ignored while busy (no ready).
module dram_cmd_responder
    import dram_pkg::*;
#(
    parameter int NUMBER_OF_BANKS  = 8,
    parameter int NUMBER_OF_ROWS   = 128,
    parameter int NUMBER_OF_COLS   = 8,
    parameter int T_RCD            = 2,
    parameter int T_CAS            = 2,
    parameter int T_RP             = 2,
    parameter int T_RFC            = 8,
    parameter int REFRESH_INTERVAL = 256,
    localparam int BW = $clog2(NUMBER_OF_BANKS),
    localparam int RW = $clog2(NUMBER_OF_ROWS),
    localparam int CW = $clog2(NUMBER_OF_COLS),
    localparam int NB = NUMBER_OF_BANKS
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          cmd_req,
    input  logic [1:0]    cmd,
    input  logic [BW-1:0] bank_id,
    input  logic [RW-1:0] row_id,
    input  logic [CW-1:0] col_id,
    output logic          cmd_ack,
    output logic          cmd_err,
    output logic [1:0]    err_code,
    output logic          refresh_flag,
    output logic          refresh_overdue,
    output logic [NB-1:0] banks_open,
    output logic          busy
);

    localparam int TW   = 8;
    localparam int CNTW = $clog2(REFRESH_INTERVAL);
    localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(REFRESH_INTERVAL - 1);

    state_e          state_q, state_d;
    cmd_e            cmd_q, cmd_d;
    logic [BW-1:0]   bank_q, bank_d;
    logic [RW-1:0]   row_q, row_d;
    logic [1:0]      err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            flag_q, flag_d, ovd_q, ovd_d;

    logic            lk_open, any_open, open_en, close_en, ref_done;
    logic [RW-1:0]   lk_row;
    logic [1:0]      chk_err;
    logic [TW-1:0]   t_load;
    logic            col_unused;

    // Column address is carried on the interface but has no row-state effect.
    assign col_unused = ^col_id;

    dram_bank_table #(.NB(NB), .BW(BW), .RW(RW)) u_bank_table (
        .clk          (clk),
        .rst_b        (rst_b),
        .lk_bank_i    (bank_id),
        .lk_open_o    (lk_open),
        .lk_row_o     (lk_row),
        .any_open_o   (any_open),
        .open_en_i    (open_en),
        .close_en_i   (close_en),
        .wr_bank_i    (bank_q),
        .wr_row_i     (row_q),
        .banks_open_o (banks_open)
    );

    always_comb begin
        chk_err = ERR_NONE;
        t_load  = TW'(T_RP);
        case (cmd_e'(cmd))
            CMD_ACT: begin
                t_load = TW'(T_RCD);
                if (lk_open) chk_err = ERR_ACT_ON_OPEN;
            end
            CMD_RW: begin
                t_load = TW'(T_CAS);
                if (!(lk_open && lk_row == row_id)) chk_err = ERR_ROW_MISS;
            end
            CMD_REF: begin
                t_load = TW'(T_RFC);
                if (any_open) chk_err = ERR_REF_NOT_IDLE;
            end
            default: t_load = TW'(T_RP);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        bank_d  = bank_q;
        row_d   = row_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: if (cmd_req) begin
                cmd_d   = cmd_e'(cmd);
                bank_d  = bank_id;
                row_d   = row_id;
                err_d   = chk_err;
                timer_d = (chk_err != ERR_NONE) ? TW'(1) : t_load;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                timer_d = timer_q - TW'(1);
                if (timer_q <= TW'(1)) state_d = ST_ACK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ack  = (state_q == ST_ACK);
    assign cmd_err  = cmd_ack && (err_q != ERR_NONE);
    assign err_code = cmd_ack ? err_q : ERR_NONE;
    assign busy     = (state_q != ST_IDLE);
    assign open_en  = cmd_ack && (err_q == ERR_NONE) && (cmd_q == CMD_ACT);
    assign close_en = cmd_ack && (cmd_q == CMD_PRE);
    assign ref_done = cmd_ack && (err_q == ERR_NONE) && (cmd_q == CMD_REF);

    // A completing REF takes priority over a coincident interval expiry.
    always_comb begin
        cnt_d  = cnt_q - CNTW'(1);
        flag_d = flag_q;
        ovd_d  = ovd_q;
        if (ref_done) begin
            cnt_d  = CNT_RELOAD;
            flag_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d  = CNT_RELOAD;
            flag_d = 1'b1;
            if (flag_q) ovd_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_ACT;
            bank_q  <= '0;
            row_q   <= '0;
            err_q   <= ERR_NONE;
            timer_q <= '0;
            cnt_q   <= CNT_RELOAD;
            flag_q  <= 1'b0;
            ovd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            ovd_q   <= ovd_d;
        end
    end

    assign refresh_flag    = flag_q;
    assign refresh_overdue = ovd_q;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Bench for dram_cmd_responder: vector table, refresh/reset sequences, random commands vs. a bank-state model.
module tb_dram_cmd_responder;

    localparam int T_RCD = 2, T_CAS = 2, T_RP = 2, T_RFC = 8;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       cmd_req = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [2:0] bank_id = '0;
    logic [6:0] row_id = '0;
    logic [2:0] col_id = '0;
    logic       cmd_ack, cmd_err, refresh_flag, refresh_overdue, busy;
    logic [1:0] err_code;
    logic [7:0] banks_open;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_b) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    dram_cmd_responder dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .cmd_req         (cmd_req),
        .cmd             (cmd),
        .bank_id         (bank_id),
        .row_id          (row_id),
        .col_id          (col_id),
        .cmd_ack         (cmd_ack),
        .cmd_err         (cmd_err),
        .err_code        (err_code),
        .refresh_flag    (refresh_flag),
        .refresh_overdue (refresh_overdue),
        .banks_open      (banks_open),
        .busy            (busy)
    );

    typedef struct {
        logic [1:0] c;
        int         b;
        int         r;
        int         col;
        int         lat;
        logic       err;
        logic [1:0] code;
        logic [7:0] banks;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b   = 1'b1;
        cmd_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the state update (-1 latency on timeout).
    task automatic do_cmd(input logic [1:0] c, input int b, input int r, input int col,
                          output int lat, output logic e, output logic [1:0] code,
                          output logic [7:0] banks);
        cmd_req = 1'b1;
        cmd     = c;
        bank_id = 3'(b);
        row_id  = 7'(r);
        col_id  = 3'(col);
        @(posedge clk);
        @(negedge clk);
        cmd_req = 1'b0;
        lat = 1;
        while (!cmd_ack && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!cmd_ack) lat = -1;
        e    = cmd_err;
        code = err_code;
        @(negedge clk);
        banks = banks_open;
    endtask

    bit         m_open [8];
    int         m_row  [8];
    int         lat;
    logic       e;
    logic [1:0] code;
    logic [7:0] banks;
    bit         saw_ack;

    initial begin
        vt[0]  = '{2'b00, 2, 5,   0, 3, 1'b0, 2'b00, 8'h04};
        vt[1]  = '{2'b01, 2, 5,   3, 3, 1'b0, 2'b00, 8'h04};
        vt[2]  = '{2'b01, 2, 6,   3, 2, 1'b1, 2'b10, 8'h04};
        vt[3]  = '{2'b00, 1, 7,   0, 3, 1'b0, 2'b00, 8'h06};
        vt[4]  = '{2'b00, 1, 7,   0, 2, 1'b1, 2'b01, 8'h06};
        vt[5]  = '{2'b11, 1, 0,   0, 3, 1'b0, 2'b00, 8'h04};
        vt[6]  = '{2'b10, 0, 0,   0, 2, 1'b1, 2'b11, 8'h04};
        vt[7]  = '{2'b11, 2, 0,   0, 3, 1'b0, 2'b00, 8'h00};
        vt[8]  = '{2'b11, 2, 0,   0, 3, 1'b0, 2'b00, 8'h00};
        vt[9]  = '{2'b10, 0, 0,   0, 9, 1'b0, 2'b00, 8'h00};
        vt[10] = '{2'b00, 7, 127, 0, 3, 1'b0, 2'b00, 8'h80};
        vt[11] = '{2'b01, 7, 127, 7, 3, 1'b0, 2'b00, 8'h80};
        vt[12] = '{2'b01, 0, 0,   1, 2, 1'b1, 2'b10, 8'h80};
        vt[13] = '{2'b11, 7, 0,   0, 3, 1'b0, 2'b00, 8'h00};

        do_reset();
        chk("rst ack",  32'(cmd_ack), 0);
        chk("rst err",  32'({cmd_err, err_code}), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst banks", 32'(banks_open), 0);
        chk("rst flags", 32'({refresh_flag, refresh_overdue}), 0);

        for (int i = 0; i < 14; i++) begin
            do_cmd(vt[i].c, vt[i].b, vt[i].r, vt[i].col, lat, e, code, banks);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d cmd_err", i), 32'(e), 32'(vt[i].err));
            chk($sformatf("vec%0d err_code", i), 32'(code), 32'(vt[i].code));
            chk($sformatf("vec%0d banks_open", i), 32'(banks), 32'(vt[i].banks));
        end
        chk("idle after vecs", 32'({busy, cmd_ack}), 0);

        // Refresh flag timing and REF legality.
        do_reset();
        wait_cyc(255);
        chk("flag before interval", 32'(refresh_flag), 0);
        wait_cyc(256);
        chk("flag at interval", 32'(refresh_flag), 1);
        do_cmd(2'b00, 0, 3, 0, lat, e, code, banks);
        do_cmd(2'b10, 0, 0, 0, lat, e, code, banks);
        chk("ref open code", 32'(code), 32'(2'b11));
        chk("ref open flag kept", 32'(refresh_flag), 1);
        do_cmd(2'b11, 0, 0, 0, lat, e, code, banks);
        do_cmd(2'b10, 0, 0, 0, lat, e, code, banks);
        chk("ref ok latency", 32'(lat), 32'(T_RFC + 1));
        chk("ref ok err", 32'(e), 0);
        chk("ref ok flag clear", 32'(refresh_flag), 0);
        chk("no overdue", 32'(refresh_overdue), 0);

        // Unserviced flag becomes overdue on the next expiry; overdue survives REF.
        do_reset();
        wait_cyc(511);
        chk("overdue before", 32'({refresh_flag, refresh_overdue}), 32'(2'b10));
        wait_cyc(512);
        chk("overdue set", 32'(refresh_overdue), 1);
        do_cmd(2'b10, 0, 0, 0, lat, e, code, banks);
        chk("overdue sticky", 32'({refresh_flag, refresh_overdue}), 32'(2'b01));

        // REF completing in the same cycle as an expiry.
        do_reset();
        wait_cyc(502);
        do_cmd(2'b10, 0, 0, 0, lat, e, code, banks);
        chk("coincide latency", 32'(lat), 32'(T_RFC + 1));
        chk("coincide cycle", 32'(cyc), 512);
        chk("coincide flags", 32'({refresh_flag, refresh_overdue}), 0);
        wait_cyc(767);
        chk("reload flag before", 32'(refresh_flag), 0);
        wait_cyc(768);
        chk("reload flag after", 32'(refresh_flag), 1);

        // Reset while a command is executing.
        do_reset();
        do_cmd(2'b00, 4, 9, 0, lat, e, code, banks);
        chk("pre-reset banks", 32'(banks), 32'(8'h10));
        cmd_req = 1'b1; cmd = 2'b00; bank_id = 3'd3; row_id = 7'd1;
        @(posedge clk);
        @(negedge clk);
        cmd_req = 1'b0;
        chk("exec busy", 32'(busy), 1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("midrst state", 32'({busy, cmd_ack, banks_open}), 0);
        saw_ack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cmd_ack) saw_ack = 1'b1;
        end
        chk("midrst no ack", 32'(saw_ack), 0);

        // Random commands against a bank-state model.
        do_reset();
        for (int b = 0; b < 8; b++) begin m_open[b] = 1'b0; m_row[b] = 0; end
        for (int i = 0; i < 150; i++) begin
            logic [1:0] c;
            int b, r, xl;
            logic [1:0] xc;
            logic [7:0] xb;
            c = 2'($urandom_range(0, 3));
            b = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            xc = 2'b00;
            case (c)
                2'b00: if (m_open[b]) xc = 2'b01;
                       else begin m_open[b] = 1'b1; m_row[b] = r; end
                2'b01: if (!(m_open[b] && m_row[b] == r)) xc = 2'b10;
                2'b10: for (int k = 0; k < 8; k++) if (m_open[k]) xc = 2'b11;
                default: m_open[b] = 1'b0;
            endcase
            case (c)
                2'b00:   xl = 1 + T_RCD;
                2'b01:   xl = 1 + T_CAS;
                2'b10:   xl = 1 + T_RFC;
                default: xl = 1 + T_RP;
            endcase
            if (xc != 2'b00) xl = 2;
            for (int k = 0; k < 8; k++) xb[k] = m_open[k];
            do_cmd(c, b, r, $urandom_range(0, 7), lat, e, code, banks);
            chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(xl));
            chk($sformatf("rnd%0d err_code", i), 32'({e, code}), 32'({xc != 2'b00, xc}));
            chk($sformatf("rnd%0d banks_open", i), 32'(banks), 32'(xb));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
